// File: rtl/atom_io_multi.sv
// atom_io_multi
// Multi-console Atom I/O block: per-console 8255 PIO registers (Port A,
// Port C low nibble, control) and a 4-entry colour palette, a shared
// 2.4 kHz cassette tone generator and vsync-synchronised display switching.
//
// Ports
//   clk, reset     : system clock, synchronous active-high reset
//   address        : [15:0] CPU address, [16 +: CON_BITS] console select
//   Din, Dout, WE  : CPU write data, combinational read data, write strobe
//   IO_sel         : CPU address lies in the #Bxxx page
//   key_col, ctrl_n, shift_n, rept_n, cass_in, vsync_n : physical inputs
//   active         : console that owns the keyboard
//   visible_req    : console requested for display (taken at vsync fall)
//   visible        : console currently displayed
//   key_row        : Port A low nibble of the active console
//   gmod           : registered graphics mode of the displayed console
//   colors         : {pal0,pal1,pal2,pal3} of the displayed console
//   speaker, tape_out : audio / cassette outputs of the displayed console
module atom_io_multi #(
  parameter int                    NUM_CON    = 4,
  parameter int                    CON_BITS   = 2,
  parameter int                    COLOR_BITS = 6,
  parameter logic [COLOR_BITS-1:0] COLOR0_RST = 6'b000011,
  parameter int                    TONE_HALF  = 5208
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [16+CON_BITS-1:0]    address,
  input  logic [7:0]                Din,
  output logic [7:0]                Dout,
  input  logic                      WE,
  output logic                      IO_sel,
  input  logic [5:0]                key_col,
  input  logic                      ctrl_n,
  input  logic                      shift_n,
  input  logic                      rept_n,
  input  logic                      cass_in,
  input  logic                      vsync_n,
  input  logic [CON_BITS-1:0]       active,
  input  logic [CON_BITS-1:0]       visible_req,
  output logic [CON_BITS-1:0]       visible,
  output logic [3:0]                key_row,
  output logic [3:0]                gmod,
  output logic [4*COLOR_BITS-1:0]   colors,
  output logic                      speaker,
  output logic                      tape_out
);

  localparam int CNT_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [CNT_W-1:0]    CNT_TC    = CNT_W'(TONE_HALF - 1);
  localparam logic [CON_BITS:0]   NUM_CON_L = (CON_BITS + 1)'(NUM_CON);

  // Per-console register state
  logic [7:0]            port_a [NUM_CON];
  logic [3:0]            port_c [NUM_CON];
  logic [COLOR_BITS-1:0] pal    [NUM_CON][4];

  logic [CON_BITS-1:0]   vis;
  logic [CNT_W-1:0]      tone_cnt;
  logic                  tone;
  logic                  vsync_q;

  logic [CON_BITS-1:0]   sel;
  logic [1:0]            off;
  logic                  sel_ok;
  logic                  req_ok;
  logic                  act_ok;
  logic                  pio_hit;
  logic                  pal_hit;
  logic                  wr_en;
  logic                  vsync_fall;
  logic [7:0]            port_b;
  logic [7:0]            pal_rd;

  // ------------------------------------------------------------------
  // Address decode
  // ------------------------------------------------------------------
  assign sel     = address[16 +: CON_BITS];
  assign off     = address[1:0];
  assign IO_sel  = (address[15:12] == 4'hB);
  // #B000-#B3FF and #BC00-#BFFF; the #B400-#BBFF hole decodes to neither
  assign pio_hit = (address[15:10] == 6'b101100);
  assign pal_hit = (address[15:10] == 6'b101111);

  // Console indices may exceed NUM_CON when NUM_CON < 2**CON_BITS
  assign sel_ok  = ({1'b0, sel}         < NUM_CON_L);
  assign req_ok  = ({1'b0, visible_req} < NUM_CON_L);
  assign act_ok  = ({1'b0, active}      < NUM_CON_L);

  assign wr_en      = WE & IO_sel & sel_ok;
  assign vsync_fall = vsync_q & ~vsync_n;

  // ------------------------------------------------------------------
  // Read path
  // ------------------------------------------------------------------
  assign port_b = (sel == active) ? {shift_n, ctrl_n, key_col} : 8'hFF;

  always_comb begin
    pal_rd = 8'h00;
    pal_rd[COLOR_BITS-1:0] = pal[sel][off];
    Dout = 8'h00;
    if (pio_hit || pal_hit) begin
      if (!sel_ok) begin
        Dout = 8'hFF;
      end else if (pal_hit) begin
        Dout = pal_rd;
      end else begin
        case (off)
          2'd0:    Dout = port_a[sel];
          2'd1:    Dout = port_b;
          2'd2:    Dout = {vsync_n, rept_n, cass_in, tone, port_c[sel]};
          default: Dout = 8'hFF;
        endcase
      end
    end
  end

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CON; i++) begin
        port_a[i] <= 8'h0F;
        port_c[i] <= 4'h0;
        pal[i][0] <= COLOR0_RST;
        pal[i][1] <= '1;
        pal[i][2] <= '1;
        pal[i][3] <= '1;
      end
      vis      <= '0;
      gmod     <= 4'h0;
      tone     <= 1'b0;
      tone_cnt <= '0;
      vsync_q  <= 1'b1;
    end else begin
      vsync_q <= vsync_n;

      if (tone_cnt == CNT_TC) begin
        tone_cnt <= '0;
        tone     <= ~tone;
      end else begin
        tone_cnt <= tone_cnt + CNT_W'(1);
      end

      // Display switches only at frame start so the picture never tears
      if (vsync_fall && req_ok) begin
        vis <= visible_req;
      end

      // Samples the pre-edge vis, giving one cycle of latency on a switch
      gmod <= port_a[vis][7:4];

      if (wr_en) begin
        if (pio_hit) begin
          case (off)
            2'd0: port_a[sel] <= Din;
            2'd2: port_c[sel] <= Din[3:0];
            2'd3: begin
              // Bit set/reset: only bits 0-3 of Port C exist here;
              // mode words (Din[7]) are accepted and discarded
              if (!Din[7] && !Din[3]) begin
                port_c[sel][Din[2:1]] <= Din[0];
              end
            end
            default: ;
          endcase
        end else if (pal_hit) begin
          pal[sel][off] <= Din[COLOR_BITS-1:0];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs of the displayed / active console
  // ------------------------------------------------------------------
  assign visible  = vis;
  assign colors   = {pal[vis][0], pal[vis][1], pal[vis][2], pal[vis][3]};
  assign speaker  = port_c[vis][2];
  assign tape_out = port_c[vis][1] ? tone : port_c[vis][0];
  assign key_row  = act_ok ? port_a[active][3:0] : 4'hF;

endmodule

// File: tb/tb_atom_io_multi.sv
module tb_atom_io_multi;

  localparam int NC = 3;
  localparam int T  = 13;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] address;
  logic [7:0]  Din;
  logic [7:0]  Dout;
  logic        WE;
  logic        IO_sel;
  logic [5:0]  key_col;
  logic        ctrl_n, shift_n, rept_n, cass_in, vsync_n;
  logic [1:0]  active, visible_req, visible;
  logic [3:0]  key_row, gmod;
  logic [23:0] colors;
  logic        speaker, tape_out;

  int n_checks = 0;
  int n_fail   = 0;
  int n_edges  = 0;

  // reference state
  logic [7:0] m_pa  [4];
  logic [3:0] m_pc  [4];
  logic [5:0] m_pal [4][4];
  int         m_vis;

  atom_io_multi #(
    .NUM_CON(NC), .CON_BITS(2), .COLOR_BITS(6),
    .COLOR0_RST(6'b000011), .TONE_HALF(T)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .Din(Din), .Dout(Dout),
    .WE(WE), .IO_sel(IO_sel), .key_col(key_col), .ctrl_n(ctrl_n),
    .shift_n(shift_n), .rept_n(rept_n), .cass_in(cass_in), .vsync_n(vsync_n),
    .active(active), .visible_req(visible_req), .visible(visible),
    .key_row(key_row), .gmod(gmod), .colors(colors), .speaker(speaker),
    .tape_out(tape_out)
  );

  always #5 clk = ~clk;

  // rising edges since reset released; the tone is a pure function of it
  always @(posedge clk) begin
    if (reset) n_edges <= 0;
    else       n_edges <= n_edges + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic m_tone();
    return 1'((n_edges / T) % 2);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 4; s++) begin
      m_pa[s] = 8'h0F;
      m_pc[s] = 4'h0;
      m_pal[s][0] = 6'h03;
      for (int e = 1; e < 4; e++) m_pal[s][e] = 6'h3F;
    end
    m_vis = 0;
  endfunction

  function automatic void model_write(int sel, int a, int d);
    int n;
    if (sel >= NC) return;
    if (a >= 'hB000 && a <= 'hB3FF) begin
      case (a % 4)
        0: m_pa[sel] = 8'(d);
        2: m_pc[sel] = 4'(d % 16);
        3: if (d < 128) begin
             n = (d / 2) % 8;
             if (n < 4) m_pc[sel][n] = 1'(d % 2);
           end
        default: ;
      endcase
    end else if (a >= 'hBC00 && a <= 'hBFFF) begin
      m_pal[sel][a % 4] = 6'(d % 64);
    end
  endfunction

  function automatic logic [7:0] model_read(int sel, int a);
    if (a >= 'hB000 && a <= 'hB3FF) begin
      if (sel >= NC) return 8'hFF;
      case (a % 4)
        0: return m_pa[sel];
        1: return (sel == int'(active)) ? {shift_n, ctrl_n, key_col} : 8'hFF;
        2: return {vsync_n, rept_n, cass_in, m_tone(), m_pc[sel]};
        default: return 8'hFF;
      endcase
    end else if (a >= 'hBC00 && a <= 'hBFFF) begin
      if (sel >= NC) return 8'hFF;
      return {2'b00, m_pal[sel][a % 4]};
    end
    return 8'h00;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(int sel, int a, int d);
    @(negedge clk);
    address = {2'(sel), 16'(a)};
    Din = 8'(d);
    WE = 1'b1;
    @(negedge clk);
    WE = 1'b0;
    model_write(sel, a, d);
  endtask

  task automatic rd(int sel, int a, string tag);
    @(negedge clk);
    address = {2'(sel), 16'(a)};
    #1;
    chk(tag, 32'(Dout), 32'(model_read(sel, a)));
    chk("io_sel", 32'(IO_sel), 32'((a / 4096) == 11));
  endtask

  task automatic vsync_pulse(int req);
    @(negedge clk);
    visible_req = 2'(req);
    vsync_n = 1'b0;
    @(negedge clk);
    vsync_n = 1'b1;
    if (req < NC) m_vis = req;
  endtask

  // one idle cycle first so gmod has caught up with the last change
  task automatic check_outs(string tag);
    logic [23:0] c_exp;
    @(negedge clk);
    #1;
    c_exp = {m_pal[m_vis][0], m_pal[m_vis][1], m_pal[m_vis][2], m_pal[m_vis][3]};
    chk({tag, "_visible"}, 32'(visible), 32'(m_vis));
    chk({tag, "_gmod"},    32'(gmod),    32'(m_pa[m_vis][7:4]));
    chk({tag, "_colors"},  32'(colors),  32'(c_exp));
    chk({tag, "_speaker"}, 32'(speaker), 32'(m_pc[m_vis][2]));
    chk({tag, "_tape"},    32'(tape_out),
        32'(m_pc[m_vis][1] ? m_tone() : m_pc[m_vis][0]));
    chk({tag, "_key_row"}, 32'(key_row), 32'(m_pa[active][3:0]));
  endtask

  function automatic int rand_addr();
    case ($urandom_range(0, 5))
      0, 1: return 'hB000 + int'($urandom_range(0, 1023));
      2, 3: return 'hBC00 + int'($urandom_range(0, 1023));
      4:    return 'hB400 + int'($urandom_range(0, 'h7FF));
      default: return int'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    reset = 1'b1; address = '0; Din = '0; WE = 1'b0;
    key_col = 6'h15; ctrl_n = 1'b1; shift_n = 1'b0; rept_n = 1'b1;
    cass_in = 1'b0; vsync_n = 1'b1; active = 2'd0; visible_req = 2'd0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    for (int s = 0; s < 4; s++) rd(s, 'hB000, "rst_porta");
    chk("rst_colors", 32'(colors), 32'({6'b000011, 6'h3F, 6'h3F, 6'h3F}));
    check_outs("rst");

    // bit set/reset on Port C
    wr(0, 'hB003, 'h05);
    wr(0, 'hB003, 'h02);
    rd(0, 'hB002, "bsr_portc");
    check_outs("bsr");
    chk("bsr_speaker", 32'(speaker), 32'(1));
    wr(0, 'hB003, 'h0F);
    wr(0, 'hB003, 'h8F);
    rd(0, 'hB002, "bsr_ignored");
    rd(0, 'hB003, "ctrl_read");

    // tone on tape_out and Port C bit 4
    wr(0, 'hB002, 'h02);
    for (int i = 0; i < 3 * T + 2; i++) begin
      @(negedge clk);
      address = {2'd0, 16'hB002};
      #1;
      chk("tone_tape", 32'(tape_out), 32'(m_tone()));
      chk("tone_pc",   32'(Dout), 32'(model_read(0, 'hB002)));
    end

    // Port B ownership
    rd(2, 'hB001, "portb_other");
    active = 2'd2;
    rd(2, 'hB001, "portb_own");
    active = 2'd0;

    // console beyond NUM_CON
    wr(3, 'hB000, 'h3C);
    rd(3, 'hB000, "sel3_read");
    rd(3, 'hBC01, "sel3_pal");
    vsync_pulse(3);
    check_outs("req3");

    // write other console, then switch to it
    wr(1, 'hB000, 'hA5);
    rd(1, 'hB000, "wr_sel1");
    check_outs("pre_switch");
    vsync_pulse(1);
    #1;
    chk("switch_visible", 32'(visible), 32'(1));
    chk("switch_gmod_lag", 32'(gmod), 32'(0));
    @(negedge clk);
    #1;
    chk("switch_gmod", 32'(gmod), 32'(4'hA));
    chk("key_row_active0", 32'(key_row), 32'(4'hF));
    active = 2'd1;
    #1;
    chk("key_row_active1", 32'(key_row), 32'(4'h5));

    // visible_req change without vsync edge
    visible_req = 2'd2;
    repeat (3) @(negedge clk);
    check_outs("req_no_vsync");

    // simultaneous write to displayed console and switch
    @(negedge clk);
    address = {2'd1, 16'hB000}; Din = 8'h70; WE = 1'b1;
    visible_req = 2'd2; vsync_n = 1'b0;
    @(negedge clk);
    WE = 1'b0; vsync_n = 1'b1;
    model_write(1, 'hB000, 'h70);
    m_vis = 2;
    rd(1, 'hB000, "simul_wr");
    check_outs("simul");

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 6))
        0, 1, 2: wr(int'($urandom_range(0, 3)), rand_addr(), int'($urandom_range(0, 255)));
        3: rd(int'($urandom_range(0, 3)), rand_addr(), "rand_rd");
        4: vsync_pulse(int'($urandom_range(0, 3)));
        5: begin
             @(negedge clk);
             visible_req = 2'($urandom_range(0, 3));
           end
        default: begin
             @(negedge clk);
             active  = 2'($urandom_range(0, NC - 1));
             key_col = 6'($urandom_range(0, 63));
             shift_n = 1'($urandom_range(0, 1));
             ctrl_n  = 1'($urandom_range(0, 1));
             rept_n  = 1'($urandom_range(0, 1));
             cass_in = 1'($urandom_range(0, 1));
           end
      endcase
      check_outs("rand");
    end

    // mid-frame reset beats a concurrent write and vsync edge
    vsync_pulse(2);
    check_outs("pre_reset");
    @(negedge clk);
    reset = 1'b1;
    address = {2'd0, 16'hB000}; Din = 8'hFF; WE = 1'b1;
    visible_req = 2'd1; vsync_n = 1'b0;
    @(negedge clk);
    reset = 1'b0; WE = 1'b0; vsync_n = 1'b1;
    model_reset();
    #1;
    chk("reset_visible", 32'(visible), 32'(0));
    rd(0, 'hB000, "reset_porta");
    check_outs("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
